// File: rtl/regfile_wr_arbiter.sv
// Two-requester round-robin arbiter for the register file write port.
// Define REGFILE_INIT_EN to add the post-reset zero-initialisation sweep.
module regfile_wr_arbiter #(
    parameter int DEPTH      = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0_valid,
    input  logic [DEPTH-1:0]      req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_data,
    input  logic                  req1_valid,
    input  logic [DEPTH-1:0]      req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  req0_ready,
    output logic                  req1_ready,
    output logic                  init_busy,
    output logic                  WE3,
    output logic [DEPTH-1:0]      A3,
    output logic [DATA_WIDTH-1:0] WD3
);

    logic                  rr_q, rr_d;
    logic                  we_q, we_d;
    logic [DEPTH-1:0]      a3_q, a3_d;
    logic [DATA_WIDTH-1:0] wd_q, wd_d;
    logic                  run;
    logic                  g0, g1;

`ifdef REGFILE_INIT_EN
    typedef enum logic {S_INIT, S_RUN} state_e;
    state_e           state_q, state_d;
    logic [DEPTH-1:0] cnt_q, cnt_d;

    assign run       = (state_q == S_RUN);
    assign init_busy = (state_q == S_INIT);
`else
    assign run       = 1'b1;
    assign init_busy = 1'b0;
`endif

    // rr_q set means req1 wins a tie
    always_comb begin
        g0 = 1'b0;
        g1 = 1'b0;
        if (run && rst_n) begin
            g0 = req0_valid && (!req1_valid || !rr_q);
            g1 = req1_valid && (!req0_valid || rr_q);
        end
    end

    assign req0_ready = g0;
    assign req1_ready = g1;

    always_comb begin
        rr_d = rr_q;
        we_d = 1'b0;
        a3_d = a3_q;
        wd_d = wd_q;
`ifdef REGFILE_INIT_EN
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == S_INIT) begin
            we_d = 1'b1;
            a3_d = cnt_q;
            wd_d = '0;
            if (cnt_q == {DEPTH{1'b1}}) begin
                state_d = S_RUN;
            end else begin
                cnt_d = cnt_q + {{(DEPTH-1){1'b0}}, 1'b1};
            end
        end else
`endif
        if (g0) begin
            rr_d = 1'b1;
            we_d = |req0_addr;
            a3_d = req0_addr;
            wd_d = req0_data;
        end else if (g1) begin
            rr_d = 1'b0;
            we_d = |req1_addr;
            a3_d = req1_addr;
            wd_d = req1_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q <= 1'b0;
            we_q <= 1'b0;
            a3_q <= '0;
            wd_q <= '0;
        end else begin
            rr_q <= rr_d;
            we_q <= we_d;
            a3_q <= a3_d;
            wd_q <= wd_d;
        end
    end

`ifdef REGFILE_INIT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
`endif

    assign WE3 = we_q;
    assign A3  = a3_q;
    assign WD3 = wd_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: vector table, reset/sweep sequences,
// and random traffic against a transaction-level reference model.
module tb_regfile_wr_arbiter;

    localparam int DEPTH = 5;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          v0 = 1'b0, v1 = 1'b0;
    logic [DEPTH-1:0] a0 = '0, a1 = '0;
    logic [DW-1:0] d0 = '0, d1 = '0;
    logic          r0, r1, busy, we;
    logic [DEPTH-1:0] a3;
    logic [DW-1:0] wd;

    regfile_wr_arbiter #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(v0), .req0_addr(a0), .req0_data(d0),
        .req1_valid(v1), .req1_addr(a1), .req1_data(d1),
        .req0_ready(r0), .req1_ready(r1), .init_busy(busy),
        .WE3(we), .A3(a3), .WD3(wd)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nmis = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        v0 = 1'b0; v1 = 1'b0;
        a0 = '0; a1 = '0; d0 = '0; d1 = '0;
    endtask

    // Reset, release, and (with the sweep built in) wait until the
    // write port is idle in RUN.
    task automatic do_reset();
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
`ifdef REGFILE_INIT_EN
        for (int k = 0; k < 100 && busy; k++) @(negedge clk);
        chk("sweep_done", busy, 1'b0);
        @(negedge clk);
`endif
    endtask

    typedef struct {
        logic v0; logic [4:0] a0; logic [31:0] d0;
        logic v1; logic [4:0] a1; logic [31:0] d1;
        logic r0; logic r1; logic we; logic cav;
        logic [4:0] a3; logic [31:0] wd;
    } vec_t;

    vec_t tbl[13];

    initial begin
        bit p0v, p1v, pref, ew, known, bad;
        logic [4:0] p0a, p1a, ea;
        logic [31:0] p0d, p1d, ed;
        int g;

        // Reset state, with a request already asserted
        v0 = 1'b1; a0 = 5'd9; d0 = 32'h9;
        #2;
        chk("rst_we", we, 1'b0);
        chk("rst_a3", a3, 0);
        chk("rst_wd", wd, 0);
        chk("rst_r0", r0, 1'b0);
        chk("rst_r1", r1, 1'b0);
`ifdef REGFILE_INIT_EN
        chk("rst_busy", busy, 1'b1);
`else
        chk("rst_busy", busy, 1'b0);
`endif
        idle_inputs();

`ifdef REGFILE_INIT_EN
        // Full sweep after release
        @(negedge clk);
        rst_n = 1'b1;
        chk("sweep_prewrite", we, 1'b0);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            chk("sweep_we", we, 1'b1);
            chk("sweep_a3", a3, i);
            chk("sweep_wd", wd, 0);
            chk("sweep_rdy", {r0, r1}, 2'b00);
            chk("sweep_busy", busy, (i < 31));
        end
        @(negedge clk);
        chk("post_sweep_busy", busy, 1'b0);
        chk("post_sweep_we", we, 1'b0);

        // Reset in the middle of the sweep, then a held-off request
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 40 && a3 != 5'd10; k++) @(negedge clk);
        chk("mid_a3", a3, 10);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_we", we, 1'b0);
        chk("mid_rst_busy", busy, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        v1 = 1'b1; a1 = 5'd7; d1 = 32'h77;
        @(negedge clk);
        chk("restart_a3", a3, 0);
        chk("restart_we", we, 1'b1);
        bad = 1'b0;
        for (int k = 0; k < 60 && !r1; k++) begin
            if (r1 && busy) bad = 1'b1;
            @(negedge clk);
        end
        chk("holdoff", bad, 1'b0);
        chk("held_grant", r1, 1'b1);
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        chk("held_we", we, 1'b1);
        chk("held_a3", a3, 7);
        chk("held_wd", wd, 32'h77);
`else
        // First edge after release writes the request
        @(negedge clk);
        rst_n = 1'b1;
        v0 = 1'b1; a0 = 5'd3; d0 = 32'h7;
        #1;
        chk("first_r0", r0, 1'b1);
        chk("first_busy", busy, 1'b0);
        chk("first_prewe", we, 1'b0);
        @(posedge clk); #1;
        idle_inputs();
        chk("first_we", we, 1'b1);
        chk("first_a3", a3, 3);
        chk("first_wd", wd, 32'h7);
`endif

        // Vector table, applied from a fresh reset
        tbl[0]  = '{1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0};
        tbl[1]  = '{1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 1'b0, 1'b1, 1'b1, 1'b1, 5'd1, 32'h11};
        tbl[2]  = '{1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 1'b1, 1'b0, 1'b1, 1'b1, 5'd2, 32'h22};
        tbl[3]  = '{1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 1'b0, 1'b1, 1'b1, 1'b1, 5'd1, 32'h11};
        tbl[4]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd2, 32'h22};
        tbl[5]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd2, 32'h22};
        tbl[6]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF};
        tbl[7]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0};
        tbl[8]  = '{1'b1, 5'd3, 32'h7, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0};
        tbl[9]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'h44, 1'b0, 1'b1, 1'b1, 1'b1, 5'd3, 32'h7};
        tbl[10] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h99, 1'b0, 1'b1, 1'b1, 1'b1, 5'd4, 32'h44};
        tbl[11] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd9, 32'h99};
        tbl[12] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 32'h99};

        do_reset();
        for (int i = 0; i < 13; i++) begin
            @(posedge clk); #1;
            v0 = tbl[i].v0; a0 = tbl[i].a0; d0 = tbl[i].d0;
            v1 = tbl[i].v1; a1 = tbl[i].a1; d1 = tbl[i].d1;
            @(negedge clk);
            chk($sformatf("vec%0d_r0", i), r0, tbl[i].r0);
            chk($sformatf("vec%0d_r1", i), r1, tbl[i].r1);
            chk($sformatf("vec%0d_we", i), we, tbl[i].we);
            if (tbl[i].cav) begin
                chk($sformatf("vec%0d_a3", i), a3, tbl[i].a3);
                chk($sformatf("vec%0d_wd", i), wd, tbl[i].wd);
            end
        end

        // Reset during a granted cycle: no write may leak out
        @(posedge clk); #1;
        v0 = 1'b1; a0 = 5'd6; d0 = 32'h66;
        @(negedge clk);
        chk("abort_r0", r0, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("abort_r0_rst", r0, 1'b0);
        chk("abort_we_rst", we, 1'b0);
        @(posedge clk); #1;
        chk("abort_we_edge", we, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("abort_we_release", we, 1'b0);
        @(posedge clk); #1;
`ifdef REGFILE_INIT_EN
        chk("abort_sweep_a3", a3, 0);
        chk("abort_sweep_busy", busy, 1'b1);
`else
        chk("abort_retry_we", we, 1'b1);
        chk("abort_retry_a3", a3, 6);
`endif
        idle_inputs();

        // Random traffic against a transaction-level model
        do_reset();
        p0v = 0; p1v = 0; pref = 0; ew = 0; known = 0;
        p0a = '0; p1a = '0; p0d = '0; p1d = '0; ea = '0; ed = '0;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            if (!p0v && $urandom_range(0, 2) != 0) begin
                p0v = 1; p0a = 5'($urandom_range(0, 31)); p0d = $urandom;
            end
            if (!p1v && $urandom_range(0, 2) != 0) begin
                p1v = 1; p1a = 5'($urandom_range(0, 31)); p1d = $urandom;
            end
            v0 = p0v; a0 = p0a; d0 = p0d;
            v1 = p1v; a1 = p1a; d1 = p1d;
            @(negedge clk);
            if (p0v && p1v) g = pref ? 1 : 0;
            else if (p0v) g = 0;
            else if (p1v) g = 1;
            else g = -1;
            chk("rnd_r0", r0, (g == 0));
            chk("rnd_r1", r1, (g == 1));
            chk("rnd_we", we, ew);
            if (known) begin
                chk("rnd_a3", a3, ea);
                chk("rnd_wd", wd, ed);
            end
            ew = 0;
            if (g >= 0) begin
                ea = (g == 0) ? p0a : p1a;
                ed = (g == 0) ? p0d : p1d;
                ew = (ea != 0);
                known = ew;
                pref = (g == 0);
                if (g == 0) p0v = 0; else p1v = 0;
            end
        end
        idle_inputs();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
